// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver producing 11-bit key events.
//
// Synchronises and deglitches the raw PS/2 clock and data lines. It receives
// 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) and folds the
// E0 (extended) and F0 (break) prefixes into a single event per key.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high; clears all state
//   ps2_clk   - raw PS/2 clock from the device (asynchronous)
//   ps2_data  - raw PS/2 data from the device (asynchronous)
//   ps2_key   - event word: [10] toggles per event, [9] press, [8] extended,
//               [7:0] scancode
//   frame_err - one-cycle pulse on a parity, stop-bit or timeout error
module ps2_key_rx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned FW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

    // Input conditioning
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            clk_f      <= 1'b1;
            clk_f_prev <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            dat_s1     <= ps2_data;
            dat_s2     <= dat_s1;
            clk_f_prev <= clk_f;
            // clk_f follows only on the FILTER-th consecutive differing cycle
            if (clk_s2 != clk_f) begin
                if (filt_cnt == FW'(FILTER - 1)) begin
                    clk_f    <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = clk_f_prev & ~clk_f;

    // Frame FSM and byte decode
    state_e        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_q, to_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            bit_q   <= '0;
            shift_q <= '0;
            to_q    <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            skip_q  <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            to_q    <= to_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        to_d    = to_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        key_d   = key_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                to_d = '0;
                if (fall && !dat_s2) begin
                    state_d = StRecv;
                    bit_d   = '0;
                end
            end
            StRecv: begin
                // Timeout wins over an edge arriving in the same cycle
                if (to_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = StIdle;
                end else if (fall) begin
                    shift_d = {dat_s2, shift_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    to_d    = '0;
                    if (bit_q == 4'd9) begin
                        state_d = StCheck;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (!(^shift_q[8:0]) || !shift_q[9]) begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else begin
                    case (shift_q[7:0])
                        // Pause: swallow the remaining 7 bytes of E1 14 77 E1 F0 14 F0 77
                        8'hE1: begin
                            skip_d = 3'd7;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end
                        8'hE0: ext_d = 1'b1;
                        8'hF0: brk_d = 1'b1;
                        8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                        default: begin
                            key_d = {~key_q[10], ~brk_q, ext_q, shift_q[7:0]};
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

    localparam int FILT = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int n_vec   = 0;
    int n_err   = 0;
    int err_cnt = 0;

    ps2_key_rx #(
        .FILTER (FILT),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles of frame_err; a single pulse adds exactly one
    always @(negedge clk) if (frame_err) err_cnt++;

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    // Drives the first nbits of a frame; glitch_bit gets a FILT-1 cycle low pulse
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            ps2_clk  = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_bit) begin
                idle(5);
                ps2_clk = 1'b0;
                idle(FILT - 1);
                ps2_clk = 1'b1;
            end
            idle(HALF);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad = 1'b0, input int glitch = -1);
        send_bits(mk(b, bad), 11, glitch);
        idle(10);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle(3);
        check_eq("reset_key", ps2_key, 11'h000);
        check_eq("reset_err", {10'd0, frame_err}, 11'd0);
        reset = 1'b0;
        idle(5);

        // Make code with latency: output registered 2+FILT+2 edges after raw stop fall
        send_bits(mk(8'h1C, 1'b0), 10, -1);
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        idle(11);
        check_eq("lat_before", ps2_key, 11'h000);
        idle(1);
        check_eq("make_1c", ps2_key, 11'h61C);
        idle(HALF - 12);
        ps2_clk = 1'b1;
        idle(HALF + 10);

        send(8'hF0);
        check_eq("f0_alone", ps2_key, 11'h61C);
        send(8'h1C);
        check_eq("break_1c", ps2_key, 11'h01C);

        send(8'hE0);
        send(8'h75);
        check_eq("ext_make", ps2_key, 11'h775);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_eq("ext_break", ps2_key, 11'h175);
        check_eq("no_err", 11'(err_cnt), 11'd0);

        send(8'h1C, 1'b1);
        check_eq("par_err", 11'(err_cnt), 11'd1);
        check_eq("par_key", ps2_key, 11'h175);
        send(8'hE0, 1'b1);
        send(8'h75);
        check_eq("par_ext_clr", ps2_key, 11'h675);
        check_eq("par_err2", 11'(err_cnt), 11'd2);

        send_bits(mk(8'h29, 1'b0), 5, -1);
        idle(TO + 10);
        check_eq("timeout_err", 11'(err_cnt), 11'd3);
        check_eq("timeout_key", ps2_key, 11'h675);
        send(8'h29);
        check_eq("after_to", ps2_key, 11'h229);

        send(8'hAA);
        check_eq("ignored_aa", ps2_key, 11'h229);
        send(8'hE0);
        send(8'hAA);
        send(8'h75);
        check_eq("aa_clr_ext", ps2_key, 11'h675);

        send(8'hE0);
        idle(2 * TO);
        send(8'h75);
        check_eq("ext_persist", ps2_key, 11'h375);

        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        check_eq("pause_key", ps2_key, 11'h375);
        send(8'h1C);
        check_eq("after_pause", ps2_key, 11'h61C);

        send(8'h1C, 1'b0, 4);
        check_eq("glitch", ps2_key, 11'h21C);
        check_eq("glitch_err", 11'(err_cnt), 11'd3);

        send_bits(mk(8'h1C, 1'b0), 3, -1);
        reset = 1'b1;
        idle(2);
        check_eq("mid_reset_key", ps2_key, 11'h000);
        check_eq("mid_reset_err", {10'd0, frame_err}, 11'd0);
        reset = 1'b0;
        idle(50);
        send(8'h1C);
        check_eq("post_reset", ps2_key, 11'h61C);
        check_eq("final_err", 11'(err_cnt), 11'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
